// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, canonical NOP, FSM states.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif

package fetch_unit_pkg;

    localparam int unsigned XLEN = `XLEN;
    localparam logic [XLEN-1:0] RV_NOP = `RV_NOP;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_ibuf.sv
// Instruction buffer: DEPTH-entry FIFO of {pc, instr} with flush.
// Push while full is accepted when a pop happens the same cycle.
module fetch_ibuf
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_push_pc,
    input  logic [XLEN-1:0] i_push_instr,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic            o_full,
    output logic            o_empty,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_instr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign o_full       = (count_q == FULL_CNT);
    assign o_empty      = (count_q == '0);
    assign o_head_pc    = pc_mem[rd_ptr_q];
    assign o_head_instr = instr_mem[rd_ptr_q];

    // Next pointer/occupancy; flush overrides any push or pop.
    always_comb begin
        do_pop   = i_pop & ~o_empty & ~i_flush;
        do_push  = i_push & ~i_flush & (~o_full | do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            pc_mem[wr_ptr_q]    <= i_push_pc;
            instr_mem[wr_ptr_q] <= i_push_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs the req/gnt/rvalid imem handshake with at
// most one request outstanding, buffers returned words and presents the head
// to decode. Optional macro FETCH_PERF_CNT_EN adds fetched/bubble counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IBUF_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instrF,
    output logic [XLEN-1:0] o_PCF,
    output logic [XLEN-1:0] o_PCPlus4F,
    output logic            o_validF,
    input  logic            i_StallF,
    input  logic            i_PCSrcE,
    input  logic [XLEN-1:0] i_PCTargetE
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     o_perf_fetched,
    output logic [31:0]     o_perf_bubble
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_pend_q, pc_pend_d;
    logic            drop_q, drop_d;

    logic            buf_full, buf_empty, push, pop;
    logic [XLEN-1:0] head_pc, head_instr, redirect_pc;

    assign redirect_pc = i_PCTargetE & ~XLEN'(3);
    assign o_imem_req  = (state_q == ST_REQ) & ~buf_full;
    assign o_imem_addr = fetch_pc_q;
    assign o_validF    = ~buf_empty;
    assign pop         = o_validF & ~i_StallF & ~i_PCSrcE;
    assign o_instrF    = o_validF ? head_instr : RV_NOP;
    assign o_PCF       = o_validF ? head_pc : '0;
    assign o_PCPlus4F  = o_validF ? (head_pc + XLEN'(4)) : '0;

    // Handshake FSM next state; a redirect overrides the PC and marks any
    // in-flight or just-granted response for discard.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_pend_d  = pc_pend_q;
        drop_d     = drop_q;
        push       = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                if (o_imem_req & i_imem_gnt) begin
                    pc_pend_d  = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = ST_WAIT;
                    drop_d     = i_PCSrcE;
                end
            end
            ST_WAIT: begin
                if (i_imem_rvalid) begin
                    push    = ~drop_q & ~i_PCSrcE;
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end else if (i_PCSrcE) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (i_PCSrcE) fetch_pc_d = redirect_pc;
    end

    // FSM and PC registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            pc_pend_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_pend_q  <= pc_pend_d;
            drop_q     <= drop_d;
        end
    end

    fetch_ibuf #(
        .DEPTH(IBUF_DEPTH)
    ) u_ibuf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_pc   (pc_pend_q),
        .i_push_instr(i_imem_rdata),
        .i_pop       (pop),
        .i_flush     (i_PCSrcE),
        .o_full      (buf_full),
        .o_empty     (buf_empty),
        .o_head_pc   (head_pc),
        .o_head_instr(head_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Counters advance per pop and per cycle with no valid head; both wrap.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_bubble_d  = perf_bubble_q + 32'(~o_validF);
    end

    // Performance counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_fetched_q <= '0;
            perf_bubble_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubble_q  <= perf_bubble_d;
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven startup/stall trace,
// directed redirect/reset sequences, and a randomized run against a
// stream-level model (head PCs form a +4 sequence restarting at each target).
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, gnt, rvalid, validF, stall, pcsrc;
    logic [31:0] addr, rdata, instrF, pcF, pc4F, target;
    logic        req2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2, pc4_2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubble, perf_fetched2, perf_bubble2;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IBUF_DEPTH(2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_gnt   (gnt),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata),
        .o_instrF     (instrF),
        .o_PCF        (pcF),
        .o_PCPlus4F   (pc4F),
        .o_validF     (validF),
        .i_StallF     (stall),
        .i_PCSrcE     (pcsrc),
        .i_PCTargetE  (target)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched(perf_fetched),
        .o_perf_bubble (perf_bubble)
`endif
    );

    fetch_unit #(
        .RESET_PC  (32'hFFFF_FFFC),
        .IBUF_DEPTH(2)
    ) dut_wrap (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (req2),
        .o_imem_addr  (addr2),
        .i_imem_gnt   (gnt),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata2),
        .o_instrF     (instr2),
        .o_PCF        (pc2),
        .o_PCPlus4F   (pc4_2),
        .o_validF     (valid2),
        .i_StallF     (stall),
        .i_PCSrcE     (pcsrc),
        .i_PCTargetE  (target)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched(perf_fetched2),
        .o_perf_bubble (perf_bubble2)
`endif
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA5C3_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance to the next sampling point.
    task automatic step(input logic s, input logic g, input logic v, input logic [31:0] d,
                        input logic r, input logic [31:0] t);
        stall  = s;
        gnt    = g;
        rvalid = v;
        rdata  = d;
        pcsrc  = r;
        target = t;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 0; gnt = 0; rvalid = 0; rdata = '0; pcsrc = 0; target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall, gnt, rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        s, g, v, r;
        logic [31:0] d, t, exp_pc, pend_addr;
        logic        pend_v;
        int unsigned pend_cnt, pops, bubbles, inv_run;

        rdata2 = 32'h0BAD_F00D;

        // Startup with gnt=1 and 1-cycle rvalid, then a 6-cycle stall.
        //            stall gnt rv  rdata         req addr        valid pc
        tbl[0]  = '{0, 1, 0, 32'h0,        1, 32'h0,  0, 32'h0};
        tbl[1]  = '{0, 0, 1, f(32'h0),     0, 32'h4,  0, 32'h0};
        tbl[2]  = '{1, 1, 0, 32'h0,        1, 32'h4,  1, 32'h0};
        tbl[3]  = '{1, 0, 1, f(32'h4),     0, 32'h8,  1, 32'h0};
        tbl[4]  = '{1, 1, 0, 32'h0,        0, 32'h8,  1, 32'h0};
        tbl[5]  = '{1, 1, 0, 32'h0,        0, 32'h8,  1, 32'h0};
        tbl[6]  = '{1, 1, 0, 32'h0,        0, 32'h8,  1, 32'h0};
        tbl[7]  = '{1, 1, 0, 32'h0,        0, 32'h8,  1, 32'h0};
        tbl[8]  = '{0, 1, 0, 32'h0,        0, 32'h8,  1, 32'h0};
        tbl[9]  = '{0, 1, 0, 32'h0,        1, 32'h8,  1, 32'h4};
        tbl[10] = '{0, 0, 1, f(32'h8),     0, 32'hC,  0, 32'h0};
        tbl[11] = '{0, 0, 0, 32'h0,        1, 32'hC,  1, 32'h8};
        tbl[12] = '{0, 0, 0, 32'h0,        1, 32'hC,  0, 32'h0};

        do_reset();
        chk("reset_valid", validF, 0);
        chk("reset_instr", instrF, NOP);
        chk("reset_pc", pcF, 0);
        chk("reset_pc4", pc4F, 0);

        for (int i = 0; i < 13; i++) begin
            chk("tbl_req", req, tbl[i].req);
            chk("tbl_addr", addr, tbl[i].addr);
            chk("tbl_valid", validF, tbl[i].valid);
            chk("tbl_pc", pcF, tbl[i].pc);
            chk("tbl_instr", instrF, tbl[i].valid ? f(tbl[i].pc) : NOP);
            chk("tbl_pc4", pc4F, tbl[i].valid ? tbl[i].pc + 32'd4 : 32'd0);
            if (i == 0) begin
                chk("wrap_req", req2, 1);
                chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
            end
            if (i == 1) chk("wrap_addr1", addr2, 32'h0);
            if (i == 2) begin
                chk("wrap_valid", valid2, 1);
                chk("wrap_pc", pc2, 32'hFFFF_FFFC);
                chk("wrap_pc4", pc4_2, 32'h0);
                chk("wrap_instr", instr2, 32'h0BAD_F00D);
            end
            step(tbl[i].stall, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, 0, 0);
        end

        // Redirect while waiting: late data for PC 0 must be dropped.
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        chk("wait_redir_req", req, 0);
        step(0, 0, 0, 0, 1, 32'h0000_0103);
        chk("wait_redir_addr", addr, 32'h100);
        chk("wait_redir_req2", req, 0);
        step(0, 0, 1, f(32'h0), 0, 0);
        chk("wait_redir_valid", validF, 0);
        chk("wait_redir_next", addr, 32'h100);
        chk("wait_redir_reqon", req, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, f(32'h100), 0, 0);
        chk("wait_redir_first_valid", validF, 1);
        chk("wait_redir_first_pc", pcF, 32'h100);
        chk("wait_redir_first_instr", instrF, f(32'h100));

        // Redirect on the same cycle the request for 0x8 is granted.
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, f(32'h0), 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, f(32'h4), 0, 0);
        chk("gnt_redir_addr8", addr, 32'h8);
        chk("gnt_redir_pc4", pcF, 32'h4);
        step(0, 1, 0, 0, 1, 32'h100);
        chk("gnt_redir_flushed", validF, 0);
        chk("gnt_redir_wait", req, 0);
        step(0, 0, 1, f(32'h8), 0, 0);
        chk("gnt_redir_dropped", validF, 0);
        chk("gnt_redir_req", req, 1);
        chk("gnt_redir_addr", addr, 32'h100);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, f(32'h100), 0, 0);
        chk("gnt_redir_pc", pcF, 32'h100);
        chk("gnt_redir_instr", instrF, f(32'h100));

        // Asynchronous reset in the middle of a pending fetch.
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, f(32'h0), 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("midwait_valid_before", validF, 1);
        stall = 0; gnt = 0;
        #2 rst = 1'b1;
        #1;
        chk("midwait_rst_valid", validF, 0);
        chk("midwait_rst_instr", instrF, NOP);
        chk("midwait_rst_pc", pcF, 0);
        chk("midwait_rst_pc4", pc4F, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midwait_rel_req", req, 1);
        chk("midwait_rel_addr", addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("midwait_perf_fetched", perf_fetched, 0);
        chk("midwait_perf_bubble", perf_bubble, 0);
`endif

        // Randomized traffic against the PC-stream model.
        do_reset();
        exp_pc = 0; pend_v = 0; pend_cnt = 0; pend_addr = 0;
        pops = 0; bubbles = 0; inv_run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (validF) begin
                chk("rnd_pc", pcF, exp_pc);
                chk("rnd_instr", instrF, f(exp_pc));
                chk("rnd_pc4", pc4F, exp_pc + 32'd4);
                inv_run = 0;
            end else begin
                chk("rnd_idle_instr", instrF, NOP);
                chk("rnd_idle_pc", pcF, 0);
                chk("rnd_idle_pc4", pc4F, 0);
                inv_run++;
            end
            chk("rnd_liveness", 32'(inv_run <= 64), 1);
            chk("rnd_align", 32'(addr[1:0]), 0);
            if (pend_v) chk("rnd_one_outstanding", req, 0);
`ifdef FETCH_PERF_CNT_EN
            chk("rnd_perf_fetched", perf_fetched, pops);
            chk("rnd_perf_bubble", perf_bubble, bubbles);
`endif
            s = ($urandom % 4) == 0;
            r = ($urandom % 12) == 0;
            t = (($urandom % 3) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom % 4096);
            v = 1'b0;
            d = $urandom;
            if (pend_v) begin
                if (pend_cnt == 0) begin
                    v = 1'b1;
                    d = f(pend_addr);
                    pend_v = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            g = ($urandom % 4) != 0;
            if (req && g) begin
                pend_v = 1'b1;
                pend_addr = addr;
                pend_cnt = $urandom % 3;
            end
            if (!validF) bubbles++;
            if (r) begin
                exp_pc = t & ~32'd3;
            end else if (validF && !s) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            step(s, g, v, d, r, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
